// File: rtl/hazard_unit.sv
// Pipeline control for a 5-stage core: latch enables, bubbles, squashes and halt,
// with one-shot cache hit capture and stall/flush statistics.
module hazard_unit #(
  parameter int REGADDR_W = 5,
  parameter int CNT_W     = 32
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic                 ihit,
  input  logic                 dhit,
  input  logic                 dmemREN_MEM,
  input  logic                 dmemWEN_MEM,
  input  logic [REGADDR_W-1:0] rs1_ID,
  input  logic [REGADDR_W-1:0] rs2_ID,
  input  logic                 uses_rs1_ID,
  input  logic                 uses_rs2_ID,
  input  logic                 MemRd_EX,
  input  logic [REGADDR_W-1:0] wsel_EX,
  input  logic                 redirect_EX,
  input  logic                 halt_WB,
  output logic                 pc_en,
  output logic                 en_IFID,
  output logic                 en_IDEX,
  output logic                 en_EXMEM,
  output logic                 en_MEMWB,
  output logic                 flush_IFID,
  output logic                 flush_IDEX,
  output logic                 dmem_req,
  output logic                 halted,
  output logic [CNT_W-1:0]     stall_cycles,
  output logic [CNT_W-1:0]     flush_count
);

  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

  state_t           state_reg, state_next;
  logic             fetch_done_reg;
  logic             dmem_done_reg;
  logic [CNT_W-1:0] stall_cycles_reg;
  logic [CNT_W-1:0] flush_count_reg;

  logic mem_req, ifetch_ok, dmem_ok, advance, lduse;

  assign mem_req   = dmemREN_MEM | dmemWEN_MEM;
  assign ifetch_ok = ihit | fetch_done_reg;
  assign dmem_ok   = !mem_req | dhit | dmem_done_reg;
  assign advance   = (state_reg == RUN) & ifetch_ok & dmem_ok;
  assign lduse     = MemRd_EX && (wsel_EX != '0) &&
                     ((uses_rs1_ID && (wsel_EX == rs1_ID)) ||
                      (uses_rs2_ID && (wsel_EX == rs2_ID)));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state_reg <= RUN;
    else       state_reg <= state_next;
  end

  // HALTED is terminal until reset.
  always_comb begin
    state_next = state_reg;
    if (state_reg == RUN && advance && halt_WB) state_next = HALTED;
  end

  always_comb begin
    pc_en      = 1'b0;
    en_IFID    = 1'b0;
    en_IDEX    = 1'b0;
    en_EXMEM   = 1'b0;
    en_MEMWB   = 1'b0;
    flush_IFID = 1'b0;
    flush_IDEX = 1'b0;
    halted     = 1'b0;
    dmem_req   = 1'b0;
    if (state_reg == HALTED) begin
      halted = 1'b1;
    end else begin
      dmem_req = mem_req & !dmem_done_reg;
      if (advance) begin
        en_IDEX  = 1'b1;
        en_EXMEM = 1'b1;
        en_MEMWB = 1'b1;
        if (halt_WB) begin
          pc_en   = 1'b1;
          en_IFID = 1'b1;
        end else if (redirect_EX) begin
          // The ID instruction is wrong-path, so squash it instead of stalling on it.
          pc_en      = 1'b1;
          en_IFID    = 1'b1;
          flush_IFID = 1'b1;
          flush_IDEX = 1'b1;
        end else if (lduse) begin
          flush_IDEX = 1'b1;
        end else begin
          pc_en   = 1'b1;
          en_IFID = 1'b1;
        end
      end
    end
  end

  // Hits that arrive while the other side still waits are held until the pipeline moves.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      fetch_done_reg <= 1'b0;
      dmem_done_reg  <= 1'b0;
    end else if (advance) begin
      fetch_done_reg <= 1'b0;
      dmem_done_reg  <= 1'b0;
    end else begin
      if (ihit && state_reg == RUN) fetch_done_reg <= 1'b1;
      if (dhit)                     dmem_done_reg  <= 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cycles_reg <= '0;
      flush_count_reg  <= '0;
    end else if (state_reg == RUN) begin
      if (!pc_en)
        stall_cycles_reg <= stall_cycles_reg + CNT_W'(1);
      if (advance && redirect_EX && !halt_WB)
        flush_count_reg <= flush_count_reg + CNT_W'(1);
    end
  end

  assign stall_cycles = stall_cycles_reg;
  assign flush_count  = flush_count_reg;

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: reset-state vector table, hand-written multi-cycle
// sequences, and a randomized run against a behavioural model.
module tb_hazard_unit;
  localparam int CW = 6;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  logic ihit, dhit, ren, wen, u1, u2, memrd, redir, halt;
  logic [4:0] rs1, rs2, wsel;
  logic pc_en, en_ifid, en_idex, en_exmem, en_memwb, fl_ifid, fl_idex, dreq, halted;
  logic [CW-1:0] stall_cycles, flush_count;
  logic [8:0] act;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  hazard_unit #(.REGADDR_W(5), .CNT_W(CW)) dut (
    .CLK(clk), .nRST(nrst), .ihit(ihit), .dhit(dhit),
    .dmemREN_MEM(ren), .dmemWEN_MEM(wen),
    .rs1_ID(rs1), .rs2_ID(rs2), .uses_rs1_ID(u1), .uses_rs2_ID(u2),
    .MemRd_EX(memrd), .wsel_EX(wsel), .redirect_EX(redir), .halt_WB(halt),
    .pc_en(pc_en), .en_IFID(en_ifid), .en_IDEX(en_idex), .en_EXMEM(en_exmem),
    .en_MEMWB(en_memwb), .flush_IFID(fl_ifid), .flush_IDEX(fl_idex),
    .dmem_req(dreq), .halted(halted),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  // {pc_en, en_IFID, en_IDEX, en_EXMEM, en_MEMWB, flush_IFID, flush_IDEX, dmem_req, halted}
  assign act = {pc_en, en_ifid, en_idex, en_exmem, en_memwb, fl_ifid, fl_idex, dreq, halted};

  typedef struct packed {
    logic ihit, dhit, ren, wen;
    logic [4:0] rs1, rs2;
    logic u1, u2, memrd;
    logic [4:0] wsel;
    logic redir, halt;
    logic [8:0] exp;
  } vec_t;

  // Flushes only mean something when the same latch is enabled.
  function automatic logic [8:0] mask(logic [8:0] v);
    logic [8:0] m;
    m = v;
    m[3] = v[3] & v[7];
    m[2] = v[2] & v[6];
    return m;
  endfunction

  task automatic chk(string name, logic [31:0] a, logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, a, e);
    end
  endtask

  task automatic drive(vec_t v);
    ihit = v.ihit; dhit = v.dhit; ren = v.ren; wen = v.wen;
    rs1 = v.rs1; rs2 = v.rs2; u1 = v.u1; u2 = v.u2;
    memrd = v.memrd; wsel = v.wsel; redir = v.redir; halt = v.halt;
  endtask

  task automatic clr();
    vec_t z;
    z = '0;
    drive(z);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_seq();
    nrst = 1'b0;
    clr();
    tick();
    nrst = 1'b1;
  endtask

  // Behavioural model: pipeline "can move" when both caches are satisfied.
  bit m_halt, m_fd, m_dd;
  int m_stall, m_flush;

  function automatic bit m_adv(vec_t v);
    return !m_halt && (v.ihit || m_fd) && (!(v.ren || v.wen) || v.dhit || m_dd);
  endfunction

  function automatic logic [8:0] m_out(vec_t v);
    bit ld;
    logic dq;
    if (m_halt) return 9'b0_0000_00_0_1;
    dq = (v.ren || v.wen) && !m_dd;
    ld = v.memrd && (v.wsel != 0) &&
         ((v.u1 && v.wsel == v.rs1) || (v.u2 && v.wsel == v.rs2));
    if (!m_adv(v)) return {7'b0, dq, 1'b0};
    if (v.halt)    return {5'b11111, 2'b00, dq, 1'b0};
    if (v.redir)   return {5'b11111, 2'b11, dq, 1'b0};
    if (ld)        return {5'b00111, 2'b01, dq, 1'b0};
    return {5'b11111, 2'b00, dq, 1'b0};
  endfunction

  task automatic m_step(vec_t v);
    logic [8:0] e;
    bit a;
    e = m_out(v);
    a = m_adv(v);
    if (!m_halt) begin
      if (!e[8]) m_stall = (m_stall + 1) % (1 << CW);
      if (a && v.redir && !v.halt) m_flush = (m_flush + 1) % (1 << CW);
      if (a) begin
        m_fd = 0;
        m_dd = 0;
        if (v.halt) m_halt = 1;
      end else begin
        if (v.ihit) m_fd = 1;
        if (v.dhit) m_dd = 1;
      end
    end else if (v.dhit) begin
      m_dd = 1;
    end
  endtask

  task automatic m_reset();
    m_halt = 0; m_fd = 0; m_dd = 0; m_stall = 0; m_flush = 0;
  endtask

  function automatic vec_t mk(logic ih, logic dh, logic rn, logic wn,
                              logic [4:0] r1, logic [4:0] r2, logic a1, logic a2,
                              logic md, logic [4:0] ws, logic rd, logic hl,
                              logic [8:0] e);
    vec_t v;
    v.ihit = ih; v.dhit = dh; v.ren = rn; v.wen = wn;
    v.rs1 = r1; v.rs2 = r2; v.u1 = a1; v.u2 = a2;
    v.memrd = md; v.wsel = ws; v.redir = rd; v.halt = hl; v.exp = e;
    return v;
  endfunction

  vec_t tbl[13];
  vec_t rv;

  initial begin
    int hcnt;
    clr();
    m_reset();

    // Vectors applied while reset holds the state at its initial values.
    tbl[0]  = mk(0,0,0,0, 0,0,0,0, 0,0, 0,0, 9'b00000_00_0_0);
    tbl[1]  = mk(1,0,0,0, 0,0,0,0, 0,0, 0,0, 9'b11111_00_0_0);
    tbl[2]  = mk(1,0,1,0, 0,0,0,0, 0,0, 0,0, 9'b00000_00_1_0);
    tbl[3]  = mk(1,1,1,0, 0,0,0,0, 0,0, 0,0, 9'b11111_00_1_0);
    tbl[4]  = mk(1,0,0,0, 0,5,0,1, 1,5, 0,0, 9'b00111_01_0_0);
    tbl[5]  = mk(1,0,0,0, 0,0,0,1, 1,0, 0,0, 9'b11111_00_0_0);
    tbl[6]  = mk(1,0,0,0, 0,5,0,0, 1,5, 0,0, 9'b11111_00_0_0);
    tbl[7]  = mk(1,0,0,0, 7,3,1,0, 1,7, 0,0, 9'b00111_01_0_0);
    tbl[8]  = mk(1,0,0,0, 0,5,0,1, 1,5, 1,0, 9'b11111_11_0_0);
    tbl[9]  = mk(1,0,0,0, 0,0,0,0, 0,0, 1,1, 9'b11111_00_0_0);
    tbl[10] = mk(0,1,0,1, 0,0,0,0, 0,0, 0,0, 9'b00000_00_1_0);
    tbl[11] = mk(1,0,0,1, 0,0,0,0, 0,0, 1,0, 9'b00000_00_1_0);
    tbl[12] = mk(1,0,0,0, 6,0,1,0, 0,6, 0,0, 9'b11111_00_0_0);
    #2;
    for (int i = 0; i < 13; i++) begin
      drive(tbl[i]);
      #1;
      chk($sformatf("table%0d", i), 32'(mask(act)), 32'(mask(tbl[i].exp)));
      $display("[TB] table %0d outputs %b", i, act);
    end
    chk("reset_stall", 32'(stall_cycles), 0);
    chk("reset_flush", 32'(flush_count), 0);

    reset_seq();
    // No hazards, ihit every cycle.
    for (int c = 0; c < 4; c++) begin
      ihit = 1'b1;
      #1;
      chk("nohaz_en", 32'(mask(act)), 32'(9'b11111_00_0_0));
      tick();
    end
    chk("nohaz_stall", 32'(stall_cycles), 0);

    // Single load-use bubble, then the same with x0 as destination.
    memrd = 1; wsel = 5; rs2 = 5; u2 = 1; ihit = 1;
    #1;
    chk("lduse_en", 32'(mask(act)), 32'(9'b00111_01_0_0));
    tick();
    memrd = 0;
    #1;
    chk("lduse_after", 32'(mask(act)), 32'(9'b11111_00_0_0));
    chk("lduse_stall", 32'(stall_cycles), 1);
    memrd = 1; wsel = 0; rs2 = 0;
    #1;
    chk("lduse_x0", 32'(mask(act)), 32'(9'b11111_00_0_0));
    tick();
    chk("lduse_x0_stall", 32'(stall_cycles), 1);
    $display("[TB] load-use sequence stall_cycles=%0d", stall_cycles);

    // Load in MEM with dhit three cycles after ihit.
    reset_seq();
    ihit = 1; ren = 1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("memwait_c%0d", c), 32'(mask(act)), 32'(9'b00000_00_1_0));
      tick();
      ihit = 0;
    end
    dhit = 1;
    #1;
    chk("memwait_adv", 32'(mask(act)), 32'(9'b11111_00_1_0));
    tick();
    chk("memwait_stall", 32'(stall_cycles), 3);
    clr();
    #1;
    chk("memwait_fetch_cleared", 32'(pc_en), 0);
    $display("[TB] memory-wait sequence stall_cycles=%0d", stall_cycles);

    // dhit two cycles before ihit: no re-request of the data access.
    reset_seq();
    ren = 1; dhit = 1;
    #1;
    chk("early_dhit_req", 32'(mask(act)), 32'(9'b00000_00_1_0));
    tick();
    dhit = 0;
    #1;
    chk("early_dhit_held", 32'(mask(act)), 32'(9'b00000_00_0_0));
    tick();
    ihit = 1;
    #1;
    chk("early_dhit_adv", 32'(mask(act)), 32'(9'b11111_00_0_0));
    tick();
    #1;
    chk("early_dhit_cleared", 32'(mask(act)), 32'(9'b00000_00_1_0));
    $display("[TB] early-dhit sequence outputs %b", act);

    // Redirect together with load-use, then halt.
    reset_seq();
    ihit = 1; memrd = 1; wsel = 5; rs2 = 5; u2 = 1; redir = 1;
    #1;
    chk("redir_lduse", 32'(mask(act)), 32'(9'b11111_11_0_0));
    tick();
    chk("redir_flush", 32'(flush_count), 1);
    chk("redir_stall", 32'(stall_cycles), 0);
    clr();
    ihit = 1; halt = 1;
    #1;
    chk("halt_adv", 32'(mask(act)), 32'(9'b11111_00_0_0));
    tick();
    halt = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("halted_out", 32'(mask(act)), 32'(9'b00000_00_0_1));
      tick();
    end
    chk("halted_stall_frozen", 32'(stall_cycles), 0);
    chk("halted_flush_frozen", 32'(flush_count), 1);
    nrst = 0;
    #1;
    chk("halt_reset_halted", 32'(halted), 0);
    chk("halt_reset_flush", 32'(flush_count), 0);
    chk("halt_reset_en", 32'(mask(act)), 32'(9'b11111_00_0_0));
    $display("[TB] halt sequence halted=%0d flush_count=%0d", halted, flush_count);
    tick();
    nrst = 1;
    clr();

    // Randomized run against the model; counters wrap at 2^CW.
    m_reset();
    hcnt = 0;
    for (int i = 0; i < 3000; i++) begin
      rv = '0;
      rv.ihit  = ($urandom_range(0, 9) < 6);
      rv.dhit  = ($urandom_range(0, 9) < 4);
      rv.ren   = ($urandom_range(0, 3) == 0);
      rv.wen   = ($urandom_range(0, 3) == 0);
      rv.rs1   = 5'($urandom_range(0, 3));
      rv.rs2   = 5'($urandom_range(0, 3));
      rv.u1    = 1'($urandom_range(0, 1));
      rv.u2    = 1'($urandom_range(0, 1));
      rv.memrd = 1'($urandom_range(0, 1));
      rv.wsel  = 5'($urandom_range(0, 3));
      rv.redir = ($urandom_range(0, 6) == 0);
      rv.halt  = ($urandom_range(0, 79) == 0);
      drive(rv);
      if (hcnt > 4 || $urandom_range(0, 299) == 0) begin
        nrst = 0;
        m_reset();
        hcnt = 0;
        #1;
        chk("rand_rst_out", 32'(mask(act)), 32'(mask(m_out(rv))));
        chk("rand_rst_stall", 32'(stall_cycles), 0);
        tick();
        nrst = 1;
        continue;
      end
      #1;
      chk("rand_out", 32'(mask(act)), 32'(mask(m_out(rv))));
      chk("rand_stall", 32'(stall_cycles), 32'(m_stall));
      chk("rand_flush", 32'(flush_count), 32'(m_flush));
      if (i % 500 == 0)
        $display("[TB] rand %0d outputs %b stall=%0d flush=%0d", i, act, stall_cycles, flush_count);
      m_step(rv);
      if (m_halt) hcnt++;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
